// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache data array: index width, fill FSM states,
// and the per-byte merge used by the write-bypass path.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } fill_state_e;

   function automatic int calc_idxw(input int sets);
      return (sets > 1) ? $clog2(sets) : 1;
   endfunction

   function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                             input logic [7:0] new_byte,
                                             input logic       en);
      return en ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/data_way_bank.sv
// One way of the data array: SETS lines of LINE_BYTES with per-byte write enables
// and an asynchronous read port (registered by the parent).
module data_way_bank
   import cache_pkg::*;
#(
   parameter  int SETS       = 4,
   parameter  int LINE_BYTES = 16,
   localparam int IDXW       = calc_idxw(SETS)
) (
   input  logic                    clk,
   input  logic [IDXW-1:0]         wr_index,
   input  logic [LINE_BYTES-1:0]   wr_be,
   input  logic [LINE_BYTES*8-1:0] wr_data,
   input  logic [IDXW-1:0]         rd_index,
   output logic [LINE_BYTES*8-1:0] rd_data
);

   logic [LINE_BYTES*8-1:0] mem [SETS];

   // NOTE: the storage has no reset; a reset port here would turn the RAM into flops.
   always_ff @(posedge clk) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
         if (wr_be[b]) mem[wr_index][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
   end

   assign rd_data = mem[rd_index];

endmodule

// File: rtl/cache_data_array.sv
// Set-associative cache data array with masked stores, beat-wise line fill and
// 1-cycle registered reads. Optional macro DATA_ARRAY_BYPASS_EN forwards same-cycle writes to reads.
module cache_data_array
   import cache_pkg::*;
#(
   parameter  int WAYS       = 4,
   parameter  int SETS       = 4,
   parameter  int LINE_BYTES = 16,
   parameter  int BEAT_BYTES = 4,
   localparam int IDXW       = calc_idxw(SETS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rd_en,
   input  logic [IDXW-1:0]              rd_index,
   input  logic [WAYS-1:0]              rd_way,
   output logic                         rd_vld,
   output logic [WAYS*LINE_BYTES*8-1:0] rd_data_all,
   output logic [LINE_BYTES*8-1:0]      rd_line,
   input  logic                         wr_en,
   output logic                         wr_ready,
   input  logic [IDXW-1:0]              wr_index,
   input  logic [WAYS-1:0]              wr_way,
   input  logic [LINE_BYTES*8-1:0]      wr_data,
   input  logic [LINE_BYTES-1:0]        wr_mask,
   input  logic                         fill_start,
   input  logic [IDXW-1:0]              fill_index,
   input  logic [WAYS-1:0]              fill_way,
   input  logic                         fill_beat_vld,
   input  logic [BEAT_BYTES*8-1:0]      fill_beat_data,
   output logic                         fill_busy,
   output logic                         fill_done
);

   localparam int BEATS = LINE_BYTES / BEAT_BYTES;
   localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LW    = LINE_BYTES * 8;

   fill_state_e           state, state_nxt;
   logic [CNTW-1:0]       cnt, cnt_nxt;
   logic [IDXW-1:0]       fill_index_q, fill_index_nxt;
   logic [WAYS-1:0]       fill_way_q, fill_way_nxt;
   logic                  st_we, fill_we, last_beat, byp_index_hit;
   logic [IDXW-1:0]       bank_index;
   logic [LW-1:0]         bank_data;
   logic [LINE_BYTES-1:0] beat_be;
   logic [LINE_BYTES-1:0] bank_be [WAYS];
   logic [LW-1:0]         bank_rd [WAYS];
   logic [WAYS*LW-1:0]    rd_all_nxt;
   logic [LW-1:0]         rd_line_nxt;

   assign wr_ready  = (state == IDLE);
   assign fill_busy = (state == FILL);
   assign fill_done = (state == DONE);
   assign st_we     = wr_en & wr_ready;
   assign fill_we   = fill_busy & fill_beat_vld;
   assign last_beat = (cnt == CNTW'(BEATS - 1));

   // Stores and fill beats are mutually exclusive (IDLE vs FILL), so one shared port suffices.
   assign bank_index = st_we ? wr_index : fill_index_q;
   assign bank_data  = st_we ? wr_data : {BEATS{fill_beat_data}};

   always_comb begin
      for (int b = 0; b < LINE_BYTES; b++) begin
         beat_be[b] = ((b / BEAT_BYTES) == int'(cnt));
      end
      for (int w = 0; w < WAYS; w++) begin
         bank_be[w] = '0;
         if (st_we && wr_way[w])           bank_be[w] = wr_mask;
         else if (fill_we && fill_way_q[w]) bank_be[w] = beat_be;
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      data_way_bank #(
         .SETS       (SETS),
         .LINE_BYTES (LINE_BYTES)
      ) u_bank (
         .clk      (clk),
         .wr_index (bank_index),
         .wr_be    (bank_be[w]),
         .wr_data  (bank_data),
         .rd_index (rd_index),
         .rd_data  (bank_rd[w])
      );
   end

`ifdef DATA_ARRAY_BYPASS_EN
   assign byp_index_hit = (bank_index == rd_index);
`else
   assign byp_index_hit = 1'b0;
`endif

   always_comb begin
      logic [LW-1:0] merged;
      // NOTE: every comb output gets a default first so no path leaves it unassigned (latch).
      rd_all_nxt  = '0;
      rd_line_nxt = '0;
      for (int w = 0; w < WAYS; w++) begin
         merged = bank_rd[w];
         for (int b = 0; b < LINE_BYTES; b++) begin
            merged[b*8 +: 8] = merge_byte(bank_rd[w][b*8 +: 8], bank_data[b*8 +: 8],
                                          byp_index_hit & bank_be[w][b]);
         end
         rd_all_nxt[w*LW +: LW] = merged;
         if (rd_way[w]) rd_line_nxt = rd_line_nxt | merged;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld      <= 1'b0;
         rd_data_all <= '0;
         rd_line     <= '0;
      end else begin
         rd_vld <= rd_en;
         if (rd_en) begin
            rd_data_all <= rd_all_nxt;
            rd_line     <= rd_line_nxt;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         fill_index_q <= '0;
         fill_way_q   <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         fill_index_q <= fill_index_nxt;
         fill_way_q   <= fill_way_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      fill_index_nxt = fill_index_q;
      fill_way_nxt   = fill_way_q;
      case (state)
         IDLE: begin
            if (fill_start) begin
               state_nxt      = FILL;
               cnt_nxt        = '0;
               fill_index_nxt = fill_index;
               fill_way_nxt   = fill_way;
            end
         end
         FILL: begin
            if (fill_beat_vld) begin
               cnt_nxt = cnt + 1'b1;
               if (last_beat) state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_data_array.sv
// Randomised scoreboard bench for cache_data_array against a byte-array reference model.
// Honours DATA_ARRAY_BYPASS_EN to select pre- or post-write read semantics.
module tb_cache_data_array;

   localparam int WAYS  = 4;
   localparam int SETS  = 4;
   localparam int LB    = 16;
   localparam int BB    = 4;
   localparam int BEATS = LB / BB;
   localparam int IDXW  = 2;
   localparam int LW    = LB * 8;
   localparam int ALLW  = WAYS * LW;

   logic            clk, rst;
   logic            rd_en, rd_vld;
   logic [IDXW-1:0] rd_index;
   logic [WAYS-1:0] rd_way;
   logic [ALLW-1:0] rd_data_all;
   logic [LW-1:0]   rd_line;
   logic            wr_en, wr_ready;
   logic [IDXW-1:0] wr_index;
   logic [WAYS-1:0] wr_way;
   logic [LW-1:0]   wr_data;
   logic [LB-1:0]   wr_mask;
   logic            fill_start, fill_beat_vld, fill_busy, fill_done;
   logic [IDXW-1:0] fill_index;
   logic [WAYS-1:0] fill_way;
   logic [BB*8-1:0] fill_beat_data;

   cache_data_array #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LB), .BEAT_BYTES(BB)) dut (
      .clk(clk), .rst(rst),
      .rd_en(rd_en), .rd_index(rd_index), .rd_way(rd_way), .rd_vld(rd_vld),
      .rd_data_all(rd_data_all), .rd_line(rd_line),
      .wr_en(wr_en), .wr_ready(wr_ready), .wr_index(wr_index), .wr_way(wr_way),
      .wr_data(wr_data), .wr_mask(wr_mask),
      .fill_start(fill_start), .fill_index(fill_index), .fill_way(fill_way),
      .fill_beat_vld(fill_beat_vld), .fill_beat_data(fill_beat_data),
      .fill_busy(fill_busy), .fill_done(fill_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ALLW-1:0] all;
      logic [ALLW-1:0] care_all;
      logic [LW-1:0]   line;
      logic [LW-1:0]   care_line;
   } rd_exp_t;

   rd_exp_t exp_q[$];
   rd_exp_t last_exp, mon_e;
   int      n_cmp = 0;
   int      n_bad = 0;

   // Reference model: byte contents, known-byte flags, and fill progress.
   logic [7:0]      mm [WAYS][SETS][LB];
   bit              kn [WAYS][SETS][LB];
   bit              m_active, m_done;
   int              m_beats;
   logic [IDXW-1:0] m_idx;
   logic [WAYS-1:0] m_way;

   task automatic check(input string name, input logic [ALLW-1:0] act, input logic [ALLW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic rd_exp_t snapshot(input logic [IDXW-1:0] idx, input logic [WAYS-1:0] way);
      rd_exp_t e;
      e.all = '0; e.care_all = '0; e.line = '0; e.care_line = '1;
      for (int w = 0; w < WAYS; w++) begin
         for (int b = 0; b < LB; b++) begin
            e.all[(w*LB+b)*8 +: 8]      = mm[w][idx][b];
            e.care_all[(w*LB+b)*8 +: 8] = kn[w][idx][b] ? 8'hFF : 8'h00;
            if (way[w]) begin
               e.line[b*8 +: 8] = e.line[b*8 +: 8] | mm[w][idx][b];
               if (!kn[w][idx][b]) e.care_line[b*8 +: 8] = 8'h00;
            end
         end
      end
      return e;
   endfunction

   task automatic model_edge();
      if (!m_active && !m_done) begin
         if (wr_en)
            for (int w = 0; w < WAYS; w++)
               for (int b = 0; b < LB; b++)
                  if (wr_way[w] && wr_mask[b]) begin
                     mm[w][wr_index][b] = wr_data[b*8 +: 8];
                     kn[w][wr_index][b] = 1'b1;
                  end
         if (fill_start) begin
            m_active = 1'b1; m_beats = 0; m_idx = fill_index; m_way = fill_way;
         end
      end else if (m_active) begin
         if (fill_beat_vld) begin
            for (int w = 0; w < WAYS; w++)
               for (int k = 0; k < BB; k++)
                  if (m_way[w]) begin
                     mm[w][m_idx][m_beats*BB+k] = fill_beat_data[k*8 +: 8];
                     kn[w][m_idx][m_beats*BB+k] = 1'b1;
                  end
            m_beats++;
            if (m_beats == BEATS) begin
               m_active = 1'b0; m_done = 1'b1;
            end
         end
      end else begin
         m_done = 1'b0;
      end
   endtask

   // Checks status against the model, predicts this edge, then advances one clock.
   task automatic step();
      rd_exp_t e;
      check("wr_ready", wr_ready, !m_active && !m_done);
      check("fill_busy", fill_busy, m_active);
      check("fill_done", fill_done, m_done);
`ifdef DATA_ARRAY_BYPASS_EN
      model_edge();
      e = snapshot(rd_index, rd_way);
`else
      e = snapshot(rd_index, rd_way);
      model_edge();
`endif
      if (rd_en) exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd_en = 0; rd_index = 0; rd_way = 0;
      wr_en = 0; wr_index = 0; wr_way = 0; wr_data = '0; wr_mask = '0;
      fill_start = 0; fill_index = 0; fill_way = 0; fill_beat_vld = 0; fill_beat_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      #1 rst = 1'b1;
      #1;
      check("rst_rd_vld", rd_vld, 0);
      check("rst_rd_data_all", rd_data_all, 0);
      check("rst_rd_line", rd_line, 0);
      check("rst_fill_busy", fill_busy, 0);
      check("rst_fill_done", fill_done, 0);
      check("rst_wr_ready", wr_ready, 1);
      m_active = 1'b0; m_done = 1'b0;
      exp_q.delete();
      last_exp = '{all: '0, care_all: '1, line: '0, care_line: '1};
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic read(input int idx, input logic [WAYS-1:0] way);
      rd_en = 1; rd_index = IDXW'(idx); rd_way = way;
      step();
      rd_en = 0;
   endtask

   task automatic beat(input logic [BB*8-1:0] d);
      fill_beat_vld = 1; fill_beat_data = d;
      step();
      fill_beat_vld = 0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rd_vld) begin
            if (exp_q.size() == 0) begin
               check("rd_vld_unexpected", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("rd_data_all", rd_data_all & mon_e.care_all, mon_e.all & mon_e.care_all);
               check("rd_line", ALLW'(rd_line & mon_e.care_line), ALLW'(mon_e.line & mon_e.care_line));
               last_exp = mon_e;
            end
         end else begin
            check("rd_line_hold", ALLW'(rd_line & last_exp.care_line), ALLW'(last_exp.line & last_exp.care_line));
            check("rd_data_all_hold", rd_data_all & last_exp.care_all, last_exp.all & last_exp.care_all);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LW-1:0] seq;
      rst = 1'b0;
      for (int w = 0; w < WAYS; w++)
         for (int s = 0; s < SETS; s++)
            for (int b = 0; b < LB; b++) begin
               mm[w][s][b] = 8'h00; kn[w][s][b] = 1'b0;
            end
      do_reset();

      // First read after reset: contents unknown, only latency is meaningful.
      read(0, 4'b0001);
      check("rd_vld_latency", rd_vld, 1);
      step();

      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            wr_en = 1; wr_index = IDXW'(s); wr_way = WAYS'(1 << w); wr_mask = '1;
            wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
         end
      wr_en = 0;

      for (int b = 0; b < LB; b++) seq[b*8 +: 8] = 8'(b);
      wr_en = 1; wr_index = 2; wr_way = 4'b0100; wr_data = seq; wr_mask = 16'h00F0;
      step();
      wr_en = 0;
      read(2, 4'b0100);
      step();

      fill_start = 1; fill_index = 1; fill_way = 4'b0001;
      step();
      fill_start = 0;
      beat(32'hA0A1A2A3);
      wr_en = 1; wr_index = 1; wr_way = 4'b0001; wr_data = '1; wr_mask = '1;
      fill_start = 1; fill_index = 3; fill_way = 4'b1000;
      beat(32'hA4A5A6A7);
      wr_en = 0; fill_start = 0;
      step();
      rd_en = 1; rd_index = 1; rd_way = 4'b0001;
      beat(32'hA8A9AAAB);
      rd_en = 0;
      beat(32'hACADAEAF);
      check("fill_done_pulse", fill_done, 1);
      step();
      read(1, 4'b0001);
      read(1, 4'b0000);
      read(1, 4'b0011);
      step();

      fill_start = 1; fill_index = 0; fill_way = 4'b0010;
      step();
      fill_start = 0;
      beat(32'h11223344);
      beat(32'h55667788);
      do_reset();
      step();
      read(0, 4'b0010);
      step();

      wr_en = 1; wr_index = 3; wr_way = 4'b0010; wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      wr_mask = 16'h5A3C;
      rd_en = 1; rd_index = 3; rd_way = 4'b0010;
      step();
      wr_en = 0; rd_en = 0;
      step();

      wr_en = 1; wr_index = 0; wr_way = 4'b1000; wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      wr_mask = '1; fill_start = 1; fill_index = 2; fill_way = 4'b1000;
      step();
      wr_en = 0; fill_start = 0;
      for (int k = 0; k < BEATS; k++) begin
         rd_en = 1; rd_index = 2; rd_way = 4'b1000;
         beat($urandom());
      end
      rd_en = 0;
      step();
      step();

      for (int i = 0; i < 600; i++) begin
         rd_en          = ($urandom_range(1, 0) == 1);
         rd_index       = IDXW'($urandom_range(SETS - 1, 0));
         rd_way         = WAYS'($urandom_range(15, 0));
         wr_en          = ($urandom_range(2, 0) == 0);
         wr_index       = IDXW'($urandom_range(SETS - 1, 0));
         wr_way         = WAYS'($urandom_range(15, 0));
         wr_data        = {$urandom(), $urandom(), $urandom(), $urandom()};
         wr_mask        = LB'($urandom());
         fill_start     = ($urandom_range(7, 0) == 0);
         fill_index     = IDXW'($urandom_range(SETS - 1, 0));
         fill_way       = ($urandom_range(3, 0) == 0) ? WAYS'($urandom_range(15, 0))
                                                      : WAYS'(1 << $urandom_range(WAYS - 1, 0));
         fill_beat_vld  = ($urandom_range(1, 0) == 1);
         fill_beat_data = $urandom();
         step();
      end
      idle_inputs();
      for (int i = 0; i < 8; i++) step();
      check("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
